// File: rtl/mips_rtype_pkg.sv
// mips_rtype_pkg: shared definitions for the multi-cycle R-type MIPS core.
//   - state_e     : core FSM states
//   - FN_*        : supported R-type funct codes
//   - *_LSB       : bit positions of the instruction fields
package mips_rtype_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/mips_rtype_mc_core_if.sv
// mips_rtype_mc_core_if: instruction-in / result-out handshake bundle.
//   instr_valid/instr_ready/instr        : instruction offer from the source
//   res_valid/res_ready/result/res_rd/illegal : result towards the consumer
//   modport master : instruction source + result consumer side
//   modport slave  : core side
interface mips_rtype_mc_core_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] result;
    logic [4:0]        res_rd;
    logic              illegal;

    modport master (
        output instr_valid, instr, res_ready,
        input  instr_ready, res_valid, result, res_rd, illegal
    );

    modport slave (
        input  instr_valid, instr, res_ready,
        output instr_ready, res_valid, result, res_rd, illegal
    );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: NUM_REGS x DATA_W register file.
//   clk, rst           : clock, synchronous active-high clear of all registers
//   ra_*/rb_*          : two asynchronous read ports (index >= NUM_REGS reads 0)
//   wb_*               : core writeback port
//   ext_*              : external preload port, has priority over writeback
// Register 0 is hardwired to zero; writes to 0 or beyond NUM_REGS are dropped.
module mips_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [4:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_we,
    input  logic [4:0]        ext_addr,
    input  logic [DATA_W-1:0] ext_data
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;

    // The core never drives both in the same cycle; ext wins anyway.
    always_comb begin
        we    = ext_we | wb_we;
        waddr = ext_we ? ext_addr : wb_addr;
        wdata = ext_we ? ext_data : wb_data;
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    regs_q[gi] <= '0;
                end
            end else begin : g_live
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_q[gi] <= '0;
                    end else if (we && (waddr == 5'(gi))) begin
                        regs_q[gi] <= wdata;
                    end
                end
            end
        end
    endgenerate

    assign ra_data = (int'(ra_addr) < NUM_REGS) ? regs_q[ra_addr] : '0;
    assign rb_data = (int'(rb_addr) < NUM_REGS) ? regs_q[rb_addr] : '0;

endmodule

// File: rtl/mips_rtype_mc_core.sv
// mips_rtype_mc_core: multi-cycle R-type MIPS execution core.
//   clk, rst            : clock, synchronous active-high reset
//   io (slave)          : instruction handshake in, result handshake out
//   ext_we/waddr/wdata  : register preload, honoured only while idle
// Flow: IDLE accepts and latches operands, EXEC computes (or starts a
// serial shift), SHIFT shifts one bit per cycle, HOLD presents the result.
// rd is written on the edge that enters HOLD.
module mips_rtype_mc_core
    import mips_rtype_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 32,
    parameter int SHIFT_SERIAL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_rtype_mc_core_if.slave   io,
    input  logic                  ext_we,
    input  logic [4:0]            ext_waddr,
    input  logic [DATA_W-1:0]     ext_wdata
);
    localparam logic SERIAL = (SHIFT_SERIAL != 0);

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d, funct_q, funct_d;
    logic [4:0]        rd_q, rd_d, shamt_q, shamt_d, sh_amt_q, sh_amt_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, sh_val_q, sh_val_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        res_rd_q, res_rd_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] rd_a, rd_b, alu_res, sh_step, wb_data;
    logic [4:0]        sh_amt;
    logic              accept, ext_we_eff, wb_we, op_shift, op_illegal;

    assign ext_we_eff     = (state_q == ST_IDLE) && ext_we;
    assign io.instr_ready = (state_q == ST_IDLE) && !ext_we && !rst;
    assign accept         = io.instr_valid && io.instr_ready;

    mips_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (io.instr[RS_LSB +: 5]),
        .ra_data  (rd_a),
        .rb_addr  (io.instr[RT_LSB +: 5]),
        .rb_data  (rd_b),
        .wb_we    (wb_we),
        .wb_addr  (rd_q),
        .wb_data  (wb_data),
        .ext_we   (ext_we_eff),
        .ext_addr (ext_waddr),
        .ext_data (ext_wdata)
    );

    // Decode and single-cycle datapath on the latched operands.
    always_comb begin
        op_shift   = 1'b0;
        op_illegal = 1'b0;
        alu_res    = '0;
        // Variable shifts (funct bit 2 set) take the amount from rs.
        sh_amt     = funct_q[2] ? rs_val_q[4:0] : shamt_q;
        if (op_q != 6'd0) begin
            op_illegal = 1'b1;
        end else begin
            case (funct_q)
                FN_ADD, FN_ADDU: alu_res = rs_val_q + rt_val_q;
                FN_SUB, FN_SUBU: alu_res = rs_val_q - rt_val_q;
                FN_AND:          alu_res = rs_val_q & rt_val_q;
                FN_OR:           alu_res = rs_val_q | rt_val_q;
                FN_XOR:          alu_res = rs_val_q ^ rt_val_q;
                FN_NOR:          alu_res = ~(rs_val_q | rt_val_q);
                FN_SLT:          alu_res = DATA_W'($signed(rs_val_q) < $signed(rt_val_q));
                FN_SLTU:         alu_res = DATA_W'(rs_val_q < rt_val_q);
                FN_SLL, FN_SLLV: begin
                    op_shift = 1'b1;
                    alu_res  = rt_val_q << sh_amt;
                end
                FN_SRL, FN_SRLV: begin
                    op_shift = 1'b1;
                    alu_res  = rt_val_q >> sh_amt;
                end
                FN_SRA, FN_SRAV: begin
                    op_shift = 1'b1;
                    alu_res  = DATA_W'($signed(rt_val_q) >>> sh_amt);
                end
                default:         op_illegal = 1'b1;
            endcase
        end
    end

    // One-bit step of the serial shifter; funct[1:0] selects the direction.
    always_comb begin
        case (funct_q[1:0])
            2'b00:   sh_step = sh_val_q << 1;
            2'b10:   sh_step = sh_val_q >> 1;
            default: sh_step = {sh_val_q[DATA_W-1], sh_val_q[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        rd_d      = rd_q;
        shamt_d   = shamt_q;
        rs_val_d  = rs_val_q;
        rt_val_d  = rt_val_q;
        sh_val_d  = sh_val_q;
        sh_amt_d  = sh_amt_q;
        result_d  = result_q;
        res_rd_d  = res_rd_q;
        illegal_d = illegal_q;
        wb_we     = 1'b0;
        wb_data   = alu_res;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = io.instr[OP_LSB +: 6];
                    rd_d     = io.instr[RD_LSB +: 5];
                    shamt_d  = io.instr[SHAMT_LSB +: 5];
                    funct_d  = io.instr[FUNCT_LSB +: 6];
                    rs_val_d = rd_a;
                    rt_val_d = rd_b;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (SERIAL && op_shift && (sh_amt != 5'd0)) begin
                    sh_val_d = rt_val_q;
                    sh_amt_d = sh_amt;
                    state_d  = ST_SHIFT;
                end else begin
                    result_d  = op_illegal ? '0 : alu_res;
                    res_rd_d  = rd_q;
                    illegal_d = op_illegal;
                    wb_we     = !op_illegal;
                    state_d   = ST_HOLD;
                end
            end
            ST_SHIFT: begin
                sh_val_d = sh_step;
                sh_amt_d = sh_amt_q - 5'd1;
                // Last step: the shifted value goes straight to result and rd.
                if (sh_amt_q == 5'd1) begin
                    result_d  = sh_step;
                    res_rd_d  = rd_q;
                    illegal_d = 1'b0;
                    wb_we     = 1'b1;
                    wb_data   = sh_step;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (io.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            funct_q   <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            rs_val_q  <= '0;
            rt_val_q  <= '0;
            sh_val_q  <= '0;
            sh_amt_q  <= '0;
            result_q  <= '0;
            res_rd_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            rd_q      <= rd_d;
            shamt_q   <= shamt_d;
            rs_val_q  <= rs_val_d;
            rt_val_q  <= rt_val_d;
            sh_val_q  <= sh_val_d;
            sh_amt_q  <= sh_amt_d;
            result_q  <= result_d;
            res_rd_q  <= res_rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign io.res_valid = (state_q == ST_HOLD);
    assign io.result    = result_q;
    assign io.res_rd    = res_rd_q;
    assign io.illegal   = illegal_q;

endmodule

// File: doc/mips_rtype_mc_core.md
# mips_rtype_mc_core

Multi-cycle, parametrised successor of the single-cycle R-type MIPS core. It accepts one 32-bit R-type instruction at a time over a valid/ready handshake, reads rs/rt from an internal clocked register file, and executes the ALU operation or an optional bit-serial shift. It writes rd back and presents the result on a valid/ready output port. It sits between an instruction source (testbench or fetch unit) and any result consumer.

## Interface
Parameters:
- DATA_W, 32, datapath and register width (8..32).
- NUM_REGS, 32, implemented registers (2..32); $0 always reads 0.
- SHIFT_SERIAL, 1, 1 = shifts take one cycle per bit; 0 = single-cycle barrel shift.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  core can accept an instruction.
- instr  in  32  MIPS R-type word.
- res_valid  out  1  result held for consumer.
- res_ready  in  1  consumer takes result.
- result  out  DATA_W  computed value.
- res_rd  out  5  destination index of result.
- illegal  out  1  qualifies result: unsupported instruction.
- ext_we  in  1  external register write (preload).
- ext_waddr  in  5  external write index.
- ext_wdata  in  DATA_W  external write data.

## Operation
- FSM states: IDLE, EXEC, SHIFT, HOLD.
- IDLE: instr_ready = !ext_we. If ext_we, write ext_wdata to ext_waddr (ignored if index 0 or ≥ NUM_REGS). Otherwise, on instr_valid && instr_ready, latch instr, rs content and rt content, then go to EXEC.
- EXEC, non-shift or SHIFT_SERIAL=0: compute, register result/res_rd/illegal, write rd, go to HOLD.
- EXEC, shift with SHIFT_SERIAL=1:
  - Load the shift register and amount.
  - If amount is 0, behave as non-shift.
  - Otherwise go to SHIFT, shifting 1 bit per cycle and decrementing the amount.
  - When the amount reaches 0, register the result, write rd, go to HOLD.
- HOLD: res_valid=1. Result fields are stable until res_valid && res_ready, then return to IDLE. ext_we is ignored outside IDLE.
- Supported when opcode==0, by funct:
  - add 0x20, addu 0x21: rs+rt.
  - sub 0x22, subu 0x23: rs−rt.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A: signed compare. sltu 0x2B: unsigned compare. Both produce 1 or 0.
  - sll 0x00, srl 0x02, sra 0x03: rt shifted by shamt.
  - sllv 0x04, srlv 0x06, srav 0x07: rt shifted by rs[4:0].
- Arithmetic wraps modulo 2^DATA_W; there is no overflow trap.
- Shift amount ≥ DATA_W: sll/srl give 0; sra gives all sign bits.
- Anything else: illegal=1, result=0, no register write.
- rd==0 or rd ≥ NUM_REGS: no write; result is still reported.
- Reads of index ≥ NUM_REGS return 0.

## Timing
- Reset values: state IDLE, all registers 0, res_valid 0, result 0, res_rd 0, illegal 0. instr_ready is 0 while rst=1 and 1 in the first cycle after.
- Non-shift latency: accept at edge E0, rd written and res_valid=1 at E1.
- Serial shift latency: res_valid at E0+1+amount.
- Barrel shift latency: same as non-shift.
- Earliest next accept: one cycle after the res handshake edge, so throughput ≤ 1 instruction per 3 cycles.
- Writeback happens at HOLD entry, so a dependent next instruction reads the new value.
- Register file: asynchronous read, synchronous write.
- rst in any state aborts the operation. The pending rd is not written, and already-written registers are cleared.
- ext_we and instr_valid in the same IDLE cycle: the external write wins and the instruction stays offered.

## Structure
- Package mips_rtype_pkg holds:
  - The state enum.
  - Funct constants.
  - Field position constants for op, rs, rt, rd, shamt and funct.
- Sub-module mips_regfile holds NUM_REGS×DATA_W with:
  - Two async read ports.
  - One sync write port, muxed between core writeback and ext.
  - $0 hardwired to 0.

## Test plan
- Preload $1=5 and $2=7 via ext_we, then issue add $3,$1,$2 -> result=12, res_rd=3, res_valid one cycle after accept, and $3 reads back 12.
- sub $4,$1,$2, then sltu $5,$4,$1 back-to-back -> first 0xFFFFFFFE, second 0. Then slt $6,$4,$1 -> 1.
- SHIFT_SERIAL=1, $2=0x80000001, sra $7,$2 with shamt 4 -> 0xF8000000 with res_valid 5 cycles after accept. shamt 0 -> latency 1.
- Hold res_ready=0 for 10 cycles -> result stable, instr_ready=0, and a new instr_valid is not accepted.
- opcode 0x08, or funct 0x01 -> illegal=1, result=0, registers unchanged. add $0,$1,$2 -> result=12, $0 reads 0.
- Assert rst during SHIFT -> next cycle IDLE, res_valid=0, and all registers read 0.
